// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin grant in IDLE, then one 8N1-style
// frame (start, DBIT data bits LSB first, stop period) paced by the 16x tick.
module uart_tx_scheduler #(
  parameter int DBIT    = 8,
  parameter int TICKS   = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            req0,
  input  logic [DBIT-1:0] data0,
  input  logic            req1,
  input  logic [DBIT-1:0] data1,
  output logic            ack0,
  output logic            ack1,
  output logic            owner,
  output logic            busy,
  output logic            tx_done,
  output logic            tx
);

  localparam int CW = $clog2((TICKS > SB_TICK) ? TICKS : SB_TICK);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [BW-1:0]   bidx_r, bidx_s;
  logic [DBIT-1:0] shift_r, shift_s;
  logic            ptr_r, ptr_s;
  logic            owner_r, owner_s;
  logic            busy_r, busy_s;
  logic            tx_r, tx_s;
  logic            ack0_r, ack0_s;
  logic            ack1_r, ack1_s;
  logic            done_r, done_s;
  logic            pick1_s;

  assign ack0    = ack0_r;
  assign ack1    = ack1_r;
  assign owner   = owner_r;
  assign busy    = busy_r;
  assign tx_done = done_r;
  assign tx      = tx_r;

  // State and output registers; every output is a flop so the TX pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bidx_r  <= '0;
      shift_r <= '0;
      ptr_r   <= 1'b0;
      owner_r <= 1'b0;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bidx_r  <= bidx_s;
      shift_r <= shift_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      busy_r  <= busy_s;
      tx_r    <= tx_s;
      ack0_r  <= ack0_s;
      ack1_r  <= ack1_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; tx_s is the line level for the state being entered.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bidx_s  = bidx_r;
    shift_s = shift_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    busy_s  = busy_r;
    tx_s    = tx_r;
    ack0_s  = 1'b0;
    ack1_s  = 1'b0;
    done_s  = 1'b0;
    // ptr_r = 1 prefers requester 1; a lone requester always wins.
    pick1_s = req1 && (!req0 || ptr_r);
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (req0 || req1) begin
          if (pick1_s) begin
            shift_s = data1;
            ack1_s  = 1'b1;
            owner_s = 1'b1;
            ptr_s   = 1'b0;
          end else begin
            shift_s = data0;
            ack0_s  = 1'b1;
            owner_s = 1'b0;
            ptr_s   = 1'b1;
          end
          busy_s  = 1'b1;
          cnt_s   = '0;
          tx_s    = 1'b0;
          state_s = START;
        end else begin
          busy_s = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_r == T_LAST) begin
            cnt_s   = '0;
            bidx_s  = '0;
            tx_s    = shift_r[0];
            state_s = DATA;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_r == T_LAST) begin
            cnt_s   = '0;
            shift_s = shift_r >> 1'b1;
            if (bidx_r == B_LAST) begin
              bidx_s  = '0;
              tx_s    = 1'b1;
              state_s = STOP;
            end else begin
              bidx_s = bidx_r + 1'b1;
              tx_s   = shift_s[0];
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_r == S_LAST) begin
            cnt_s   = '0;
            tx_s    = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        cnt_s   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: decodes each frame tick by tick and
// checks grant order, frame contents, timing, stall and asynchronous reset.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, owner, busy, tx_done, tx;

  logic       tick_en;
  logic [1:0] div;
  int         n_checks = 0;
  int         n_pass   = 0;

  uart_tx_scheduler #(.DBIT(8), .TICKS(16), .SB_TICK(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .owner(owner), .busy(busy),
    .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;

  // One-clock tick every 4 clocks; disabling freezes the phase.
  initial begin
    tick = 1'b0;
    div  = 2'd0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div  = div + 2'd1;
        tick = (div == 2'd0);
      end else begin
        tick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a grant, then follow 160 ticks decoding the line level before each tick edge.
  task automatic run_frame(input string tag, input logic exp_own, input logic [7:0] exp_byte,
                           input bit drop, input int stall_at, input int exp_wait);
    int w, nt, clocks, first, idx, k;
    logic txp, tx_ref;
    logic [7:0] got_byte;
    bit start_bad, stop_bad, glitch, early_done, extra_ack, stall_bad;
    w = 0;
    do begin step(); w++; end while (!(ack0 || ack1) && w < 2000);
    check({tag, " wait"}, w, exp_wait);
    check({tag, " ack"}, {ack1, ack0}, exp_own ? 2 : 1);
    check({tag, " owner"}, owner, exp_own);
    check({tag, " busy"}, busy, 1);
    if (drop) begin
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    txp = tx; nt = 0; clocks = 0; first = 0; got_byte = 8'h00;
    start_bad = 0; stop_bad = 0; glitch = 0; early_done = 0; extra_ack = 0; stall_bad = 0;
    while (nt < 160 && clocks < 5000) begin
      step();
      clocks++;
      if (ack0 || ack1) extra_ack = 1;
      if (tick) begin
        nt++;
        k = nt;
        if (nt == 1) first = clocks;
        if (k <= 16) start_bad |= (txp !== 1'b0);
        else if (k <= 144) begin
          idx = (k - 17) / 16;
          if ((k - 17) % 16 == 0) got_byte[idx] = txp;
          else if (txp !== got_byte[idx]) glitch = 1;
        end else stop_bad |= (txp !== 1'b1);
        if (nt == stall_at) begin
          tick_en = 1'b0;
          tx_ref  = tx;
          for (int s = 0; s < 100; s++) begin
            step();
            clocks++;
            if (tx !== tx_ref || !busy || tick || tx_done) stall_bad = 1;
          end
          tick_en = 1'b1;
        end
      end
      if (tx_done && nt != 160) early_done = 1;
      txp = tx;
    end
    check({tag, " start"}, start_bad, 0);
    check({tag, " byte"}, got_byte, exp_byte);
    check({tag, " bit glitch"}, glitch, 0);
    check({tag, " stop"}, stop_bad, 0);
    check({tag, " done"}, tx_done, 1);
    check({tag, " early done"}, early_done, 0);
    check({tag, " extra ack"}, extra_ack, 0);
    check({tag, " busy end"}, busy, 0);
    check({tag, " clocks"}, clocks, first + 636 + ((stall_at > 0) ? 100 : 0));
    if (stall_at > 0) check({tag, " stall"}, stall_bad, 0);
  endtask

  initial begin
    int w, nt;
    bit bad;
    rst_n = 1'b0; tick_en = 1'b1;
    req0 = 1'b1; req1 = 1'b0; data0 = 8'hA5; data1 = 8'h00;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst tx", tx, 1);
      check("rst busy", busy, 0);
      check("rst ack0", ack0, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    run_frame("single", 1'b0, 8'hA5, 1'b1, 0, 1);
    step();
    check("single done pulse", tx_done, 0);
    check("single idle tx", tx, 1);

    // Contention from reset: both held, grants alternate.
    rst_n = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    @(negedge clk) rst_n = 1'b1;
    run_frame("cont0", 1'b0, 8'h11, 1'b0, 0, 1);
    run_frame("cont1", 1'b1, 8'h22, 1'b0, 0, 1);
    run_frame("cont2", 1'b0, 8'h11, 1'b0, 0, 1);
    run_frame("cont3", 1'b1, 8'h22, 1'b1, 0, 1);
    req0 = 1'b0;
    step(); step();
    check("idle ack0", ack0, 0);
    check("idle busy", busy, 0);

    // Lone req1 frame, then both: req0 must win; stall the req0 frame mid-data.
    req1 = 1'b1; data1 = 8'h5A;
    run_frame("fair1", 1'b1, 8'h5A, 1'b1, 0, 1);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h3C; data1 = 8'h00;
    run_frame("fair0", 1'b0, 8'h3C, 1'b1, 60, 1);

    // req1 still pending: grant it, then reset during data bit 3.
    w = 0;
    do begin step(); w++; end while (!ack1 && w < 2000);
    check("mid ack1", w, 1);
    req1 = 1'b0;
    nt = 0; w = 0;
    while (nt < 72 && w < 2000) begin
      step(); w++;
      if (tick) nt++;
    end
    check("mid pre tx", tx, 0);
    check("mid pre busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid rst tx", tx, 1);
    check("mid rst busy", busy, 0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1 || busy || tx_done || ack0 || ack1) bad = 1;
    end
    check("mid post idle", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one serial TX line, driven by the 16x oversampling tick from the baud rate generator, between two byte requesters.
- Round-robin arbitration selects the next requester when the line is idle.
- The granted byte is latched and sent as an 8N1-style frame: start bit, DBIT data bits LSB first, stop period.
- Sits between the baud rate generator (tick source) and the board TX pin; requesters are upstream command/data producers.

Parameters:
DBIT, 8, number of data bits per frame.
TICKS, 16, tick pulses per bit period (oversampling factor; must match the generator).
SB_TICK, 16, tick pulses in the stop period (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
tick  input  1  one-clk-wide pulse at TICKS x baud, from baud rate generator.
req0  input  1  requester 0 wants to send; held high with data0 stable until ack0.
data0  input  DBIT  byte from requester 0.
req1  input  1  requester 1 wants to send; held high with data1 stable until ack1.
data1  input  DBIT  byte from requester 1.
ack0  output  1  one-cycle pulse: data0 latched.
ack1  output  1  one-cycle pulse: data1 latched.
owner  output  1  index of requester whose frame is on the line (valid while busy).
busy  output  1  high from the cycle after grant until the frame ends.
tx_done  output  1  one-cycle pulse when the stop period completes.
tx  output  1  serial line, idle high.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; tx=1; busy=0; ack0=ack1=0; tx_done=0; owner=0.
  - Tick counter, bit counter and shift register cleared; priority pointer favours req0.
  - Any frame in progress is abandoned with no ack or done.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If any req is high at a clk edge, grant per round-robin: the pointer names the preferred requester; if only one requests, it wins.
  - On the grant edge:
    - latch the winner's data into the shift register;
    - pulse ack of the winner for exactly 1 cycle;
    - set owner; set busy=1;
    - move pointer to the other requester; clear tick counter; go to START.
  - Ticks in IDLE are ignored.
- START:
  - tx=0.
  - Counts ticks; on the tick where counter==TICKS-1, clear the counter and bit index and go to DATA.
- DATA:
  - tx=shift[0].
  - On the tick where counter==TICKS-1: shift right by one and increment the bit index.
  - If the index was DBIT-1, go to STOP; otherwise stay.
- STOP:
  - tx=1.
  - On the tick where counter==SB_TICK-1, go to IDLE, pulse tx_done for 1 cycle and drop busy in the same cycle.
- Counter rules:
  - Counters advance only on clk edges with tick=1. With tick held low, the state is frozen and tx holds.
  - Tick counter width is ceil(log2(max(TICKS,SB_TICK))); bit index width is ceil(log2(DBIT)). No wrap beyond the terminal values.
- Frame length: exactly (1+DBIT)*TICKS + SB_TICK ticks after the grant. Default 160 ticks.
- Back-to-back: a request pending at the edge where STOP completes is not granted that edge. It is granted on the next edge in IDLE, so there is a minimum 1 idle cycle with tx=1.
- Requests and data changing while busy do not affect the frame in flight.
- A req that falls before its ack is simply not served; no error.
- ack and tx_done are never asserted in the same cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 clk, with tick every 4 clk and req0=1 -> tx=1, busy=0, no ack; after release, ack0 pulses on the first edge.
- Single frame: req0=1, data0=0xA5, tick every 4 clk -> ack0 one cycle, owner=0.
  - tx is 0 for 16 ticks, then bits 1,0,1,0,0,1,0,1 for 16 ticks each, then 1 for 16 ticks.
  - tx_done pulses once, 640 clk after the grant.
- Contention: req0=req1=1 (0x11, 0x22) from reset -> 0x11 sent first (owner=0), then 0x22 (owner=1) after exactly 1 idle cycle.
  - With both still requesting, grants alternate 0,1,0,1.
- Fairness: after a req1 frame with req0 low, assert req0 and req1 together -> req0 is granted.
- Mid-frame reset: assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 immediately (asynchronous). No tx_done; after release the line is idle.
- Tick stall: hold tick=0 for 100 clk during DATA -> tx and state unchanged. On resume, the remaining bit period completes with the correct tick count.
